// File: rtl/nibble_add_seq_if.sv
// Request/result bundle for nibble_add_seq: operands and start in, busy/done/sum/cout out.
// The sub line exists only when NIBBLE_SUB_EN is defined.
interface nibble_add_seq_if;
  logic        start;
`ifdef NIBBLE_SUB_EN
  logic        sub;
`endif
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  modport master (
`ifdef NIBBLE_SUB_EN
    output sub,
`endif
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef NIBBLE_SUB_EN
    input  sub,
`endif
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_add_seq.sv
// 16-bit add (subtract with NIBBLE_SUB_EN) sequenced one nibble per cycle through an
// external 4-bit adder, carry chained between nibbles in a register.
module nibble_add_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_add_seq_if.slave      bus,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_c0,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  k;
  logic        carry;
  logic [15:0] a_lat;
  logic [15:0] b_lat;
  logic [15:0] sum_q;
  logic        cout_q;
  logic        busy_q;
  logic        done_q;
  logic        sub_in;
  logic        sub_lat;
  logic        accept;

`ifdef NIBBLE_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in  = 1'b0;
  assign sub_lat = 1'b0;
`endif

  // DONE's exit edge doubles as the IDLE sample point, giving one operation per 5 cycles.
  assign accept = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef NIBBLE_SUB_EN
      sub_lat <= 1'b0;
`endif
    end else if (accept) begin
      state  <= RUN;
      k      <= '0;
      carry  <= sub_in;
      a_lat  <= bus.a;
      b_lat  <= bus.b;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
`ifdef NIBBLE_SUB_EN
      sub_lat <= sub_in;
`endif
    end else begin
      case (state)
        RUN: begin
          sum_q[{k, 2'b00} +: 4] <= add_s;
          carry <= add_cout;
          k     <= k + 2'd1;
          if (k == 2'd3) begin
            cout_q <= add_cout;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state == RUN) begin
      add_a  = a_lat[{k, 2'b00} +: 4];
      add_b  = b_lat[{k, 2'b00} +: 4] ^ {4{sub_lat}};
      add_c0 = carry;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: stimulus pushes expected results, a negedge
// monitor pops them on done; the external 4-bit adder is modelled here.
module tb_nibble_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_c0, add_cout;

  nibble_add_seq_if bus();

  nibble_add_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_c0   (add_c0),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] model_result(input logic [15:0] a, b, input logic s);
    logic [15:0] nb;
    nb = ~b;
    if (s) return {1'b0, a} + {1'b0, nb} + 17'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Carry entering nibble k is the carry out of the low 4k bits of the full-width sum.
  function automatic logic model_carry_in(input logic [15:0] a, b, input logic s,
                                          input int unsigned k);
    int unsigned m, bb, t;
    m  = (32'd1 << (4 * k)) - 32'd1;
    bb = s ? {16'h0, ~b} : {16'h0, b};
    t  = ({16'h0, a} & m) + (bb & m) + {31'h0, s};
    return ((t >> (4 * k)) & 32'd1) != 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("sum", {16'h0, bus.sum}, {16'h0, e.sum});
          chk("cout", {31'h0, bus.cout}, {31'h0, e.cout});
          chk("busy_with_done", {31'h0, bus.busy}, 32'd1);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        void'(sb.pop_front());
        chk("done_timeout", 32'd0, 32'd1);
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, b, input logic s, input int unsigned due);
    logic [16:0] r;
    exp_t e;
    r = model_result(a, b, s);
    e.sum = r[15:0];
    e.cout = r[16];
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic st, input logic [15:0] a, b, input logic s);
    bus.start = st;
    bus.a = a;
    bus.b = b;
`ifdef NIBBLE_SUB_EN
    bus.sub = s;
`endif
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] a, b, input logic s, input logic scramble);
    @(negedge clk);
    drive_req(1'b1, a, b, s);
    push_exp(a, b, s, cyc + 5);
    @(negedge clk);
    drive_req(1'b0, scramble ? 16'hAAAA : a, scramble ? 16'h5555 : b, ~s);
    for (int unsigned k = 0; k < 4; k++) begin
      chk($sformatf("add_c0_n%0d", k), {31'h0, add_c0}, {31'h0, model_carry_in(a, b, s, k)});
      chk($sformatf("add_a_n%0d", k), {28'h0, add_a}, {28'h0, a[4*k +: 4]});
      chk($sformatf("add_b_n%0d", k), {28'h0, add_b},
          {28'h0, (s ? ~b[4*k +: 4] : b[4*k +: 4])});
      if (k < 3) @(negedge clk);
    end
    wait_drain();
  endtask

  logic sub_ok;

  initial begin
`ifdef NIBBLE_SUB_EN
    sub_ok = 1'b1;
`else
    sub_ok = 1'b0;
`endif
    drive_req(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sum", {16'h0, bus.sum}, 32'h0);
    chk("rst_cout", {31'h0, bus.cout}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("idle_add_pins", {23'h0, add_a, add_b, add_c0}, 32'h0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("sum_hold", {16'h0, bus.sum}, 32'h5555);
    chk("idle_busy", {31'h0, bus.busy}, 32'h0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'h2222, 1'b0, 1'b1);

    // start held for 8 edges: accepted at E0 and again at E5
    @(negedge clk);
    drive_req(1'b1, 16'h0001, 16'h0001, 1'b0);
    push_exp(16'h0001, 16'h0001, 1'b0, cyc + 5);
    push_exp(16'h0001, 16'h0001, 1'b0, cyc + 10);
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // reset sampled at E2 aborts the operation
    @(negedge clk);
    drive_req(1'b1, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_sum", {16'h0, bus.sum}, 32'h0);
    chk("abort_cout", {31'h0, bus.cout}, 32'h0);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_add_pins", {23'h0, add_a, add_b, add_c0}, 32'h0);
    repeat (8) @(negedge clk);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);

    if (sub_ok) begin
      run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
      run_op(16'h0009, 16'h0003, 1'b1, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b1, 1'b0);
    end

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = sub_ok & 1'($urandom);
      run_op(ra, rb, rs, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
